// File: rtl/toy_serial_byte_rx.sv
// toy_serial_byte_rx: 8N1 serial receiver (LSB first) that feeds the toy byte
// loader. Each good byte is presented on data with a one-cycle load_enable
// strobe. A frame whose stop bit samples low raises a one-cycle frame_error
// pulse and is never strobed.
module toy_serial_byte_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       load_enable,
    output logic       frame_error,
    output logic       busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_d;
    logic          load_enable_d;
    logic          frame_error_d;
    logic          rx_meta;
    logic          rx_s;

    // Two-flop synchronizer. It resets to the idle-high line level so that
    // releasing reset cannot look like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State register. The strobes and data are registered here, so they
    // appear in the cycle after the stop-bit sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data        <= 8'h00;
            load_enable <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data        <= data_d;
            load_enable <= load_enable_d;
            frame_error <= frame_error_d;
        end
    end

    // Next-state logic. START samples at HALF-1 to find the middle of the
    // start bit; every later sample is one full bit period on, which keeps
    // each sample at its bit centre.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        data_d        = data;
        load_enable_d = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d        = shift_q;
                        load_enable_d = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // busy follows the state register directly: any state other than IDLE.
    always_comb begin
        busy = (state_q != IDLE);
    end

endmodule

// File: tb/tb_toy_serial_byte_rx.sv
// Testbench for toy_serial_byte_rx. Runs one instance with 4 clocks per bit
// and one with 16 clocks per bit. Inputs are driven and outputs are
// observed on the falling clock edge.
module tb_toy_serial_byte_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_a;
    logic       rx_b;
    logic [7:0] data_a, data_b;
    logic       load_enable_a, load_enable_b;
    logic       frame_error_a, frame_error_b;
    logic       busy_a, busy_b;

    int checks = 0;
    int failures = 0;

    int cycle = 0;
    int le_count_a = 0;
    int fe_count_a = 0;
    int le_count_b = 0;
    int fe_count_b = 0;
    int overlap_errors = 0;
    logic [7:0] le_data_a [0:31];
    int         le_cycle_a [0:31];
    logic [7:0] le_data_b = 8'h00;
    logic prev_le_a = 1'b0, prev_fe_a = 1'b0, prev_le_b = 1'b0, prev_fe_b = 1'b0;

    toy_serial_byte_rx #(.CLKS_PER_BIT(4)) u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx_a),
        .data        (data_a),
        .load_enable (load_enable_a),
        .frame_error (frame_error_a),
        .busy        (busy_a)
    );

    toy_serial_byte_rx #(.CLKS_PER_BIT(16)) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx_b),
        .data        (data_b),
        .load_enable (load_enable_b),
        .frame_error (frame_error_b),
        .busy        (busy_b)
    );

    // 10 time-unit clock period
    always #5 clk = ~clk;

    // Free-running cycle count used to time strobe spacing
    always @(posedge clk) cycle <= cycle + 1;

    // Strobe monitor: logs every pulse and flags same-cycle or back-to-back pulses
    always @(negedge clk) begin
        if (load_enable_a) begin
            if (le_count_a < 32) begin
                le_data_a[le_count_a]  = data_a;
                le_cycle_a[le_count_a] = cycle;
            end
            le_count_a++;
        end
        if (frame_error_a) fe_count_a++;
        if (load_enable_b) begin
            le_data_b = data_b;
            le_count_b++;
        end
        if (frame_error_b) fe_count_b++;
        if ((load_enable_a && frame_error_a) || (load_enable_a && prev_le_a) ||
            (frame_error_a && prev_fe_a) || (load_enable_b && frame_error_b) ||
            (load_enable_b && prev_le_b) || (frame_error_b && prev_fe_b))
            overlap_errors++;
        prev_le_a = load_enable_a;
        prev_fe_a = frame_error_a;
        prev_le_b = load_enable_b;
        prev_fe_b = frame_error_b;
    end

    // Drives one 8N1 frame on rx_a (4 clocks per bit); call on a falling edge
    task automatic send_frame_a(input logic [7:0] value, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, value, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_a = bits[i];
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_a, load_enable_a, frame_error_a, busy_a} !== 11'h000) begin
            failures++;
            $display("[TB] FAIL reset_held_a: got %h expected 000", {data_a, load_enable_a, frame_error_a, busy_a});
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_a, load_enable_a, frame_error_a, busy_a} !== 11'h000) begin
            failures++;
            $display("[TB] FAIL reset_released_a: got %h expected 000", {data_a, load_enable_a, frame_error_a, busy_a});
        end
        checks++;
        if ({data_b, load_enable_b, frame_error_b, busy_b} !== 11'h000) begin
            failures++;
            $display("[TB] FAIL reset_released_b: got %h expected 000", {data_b, load_enable_b, frame_error_b, busy_b});
        end
    endtask

    task automatic test_single_frame();
        int le_base, fe_base;
        le_base = le_count_a;
        fe_base = fe_count_a;
        send_frame_a(8'hA5, 1'b1);
        rx_a = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (le_count_a - le_base !== 1) begin
            failures++;
            $display("[TB] FAIL single_strobes: got %0d expected 1", le_count_a - le_base);
        end
        checks++;
        if (le_data_a[le_base] !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL single_strobe_data: got %h expected a5", le_data_a[le_base]);
        end
        checks++;
        if (data_a !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL single_data_held: got %h expected a5", data_a);
        end
        checks++;
        if (fe_count_a - fe_base !== 0) begin
            failures++;
            $display("[TB] FAIL single_no_frame_error: got %0d expected 0", fe_count_a - fe_base);
        end
    endtask

    task automatic test_back_to_back();
        int le_base;
        le_base = le_count_a;
        send_frame_a(8'h3C, 1'b1);
        send_frame_a(8'hFF, 1'b1);
        rx_a = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (le_count_a - le_base !== 2) begin
            failures++;
            $display("[TB] FAIL b2b_strobes: got %0d expected 2", le_count_a - le_base);
        end
        checks++;
        if (le_data_a[le_base] !== 8'h3C || le_data_a[le_base + 1] !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL b2b_data: got %h,%h expected 3c,ff", le_data_a[le_base], le_data_a[le_base + 1]);
        end
        checks++;
        if (le_cycle_a[le_base + 1] - le_cycle_a[le_base] !== 40) begin
            failures++;
            $display("[TB] FAIL b2b_spacing: got %0d expected 40", le_cycle_a[le_base + 1] - le_cycle_a[le_base]);
        end
        checks++;
        if (data_a !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL b2b_data_held: got %h expected ff", data_a);
        end
    endtask

    task automatic test_frame_error();
        int le_base, fe_base;
        le_base = le_count_a;
        fe_base = fe_count_a;
        send_frame_a(8'h12, 1'b0);
        rx_a = 1'b0;
        repeat (16) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ferr_busy_while_low: got %b expected 1", busy_a);
        end
        rx_a = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ferr_busy_sync_lag: got %b expected 1", busy_a);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ferr_busy_released: got %b expected 0", busy_a);
        end
        checks++;
        if (fe_count_a - fe_base !== 1 || le_count_a - le_base !== 0) begin
            failures++;
            $display("[TB] FAIL ferr_pulses: got fe=%0d le=%0d expected fe=1 le=0", fe_count_a - fe_base, le_count_a - le_base);
        end
        checks++;
        if (data_a !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL ferr_data_kept: got %h expected ff", data_a);
        end
        le_base = le_count_a;
        send_frame_a(8'h34, 1'b1);
        rx_a = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (data_a !== 8'h34 || le_count_a - le_base !== 1) begin
            failures++;
            $display("[TB] FAIL ferr_recovery: got data=%h strobes=%0d expected data=34 strobes=1", data_a, le_count_a - le_base);
        end
    endtask

    task automatic test_glitch();
        int le_base, fe_base;
        logic saw_busy;
        le_base  = le_count_a;
        fe_base  = fe_count_a;
        saw_busy = 1'b0;
        rx_a = 1'b0;
        @(negedge clk);
        rx_a = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (busy_a) saw_busy = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (saw_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL glitch_busy_pulse: got %b expected 1", saw_busy);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("[TB] FAIL glitch_back_idle: got %b expected 0", busy_a);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (le_count_a - le_base !== 0 || fe_count_a - fe_base !== 0) begin
            failures++;
            $display("[TB] FAIL glitch_no_strobe: got le=%0d fe=%0d expected 0 0", le_count_a - le_base, fe_count_a - fe_base);
        end
    endtask

    task automatic test_reset_mid_frame();
        int le_base, fe_base;
        logic [9:0] bits;
        le_base = le_count_a;
        fe_base = fe_count_a;
        bits = {1'b1, 8'hC3, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx_a = bits[i];
            repeat (4) @(negedge clk);
        end
        rx_a = bits[5];
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rx_a  = 1'b1;
        #1;
        checks++;
        if (busy_a !== 1'b0 || data_a !== 8'h00 || load_enable_a !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_immediate: got busy=%b data=%h le=%b expected 0 00 0", busy_a, data_a, load_enable_a);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (le_count_a - le_base !== 0 || fe_count_a - fe_base !== 0 || data_a !== 8'h00) begin
            failures++;
            $display("[TB] FAIL midreset_aborted: got le=%0d fe=%0d data=%h expected 0 0 00", le_count_a - le_base, fe_count_a - fe_base, data_a);
        end
        send_frame_a(8'h5A, 1'b1);
        rx_a = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (data_a !== 8'h5A || le_count_a - le_base !== 1) begin
            failures++;
            $display("[TB] FAIL midreset_recovery: got data=%h strobes=%0d expected data=5a strobes=1", data_a, le_count_a - le_base);
        end
    endtask

    // Each data and stop bit carries its true value only in a 4-cycle window
    // around the bit centre and the opposite level elsewhere, so the byte
    // only arrives intact if every sample lands within about one cycle of centre.
    task automatic test_bit_centre_16();
        int le_base, fe_base;
        logic [8:0] bits;
        logic val;
        le_base = le_count_b;
        fe_base = fe_count_b;
        bits = {1'b1, 8'h81};
        rx_b = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            val = bits[i];
            for (int k = 0; k < 16; k++) begin
                if (k >= 6 && k <= 9) rx_b = val;
                else if (i == 8 && k > 9) rx_b = 1'b1;
                else rx_b = ~val;
                @(negedge clk);
            end
        end
        rx_b = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (le_count_b - le_base !== 1 || fe_count_b - fe_base !== 0) begin
            failures++;
            $display("[TB] FAIL centre16_pulses: got le=%0d fe=%0d expected 1 0", le_count_b - le_base, fe_count_b - fe_base);
        end
        checks++;
        if (le_data_b !== 8'h81 || data_b !== 8'h81) begin
            failures++;
            $display("[TB] FAIL centre16_data: got strobe=%h held=%h expected 81", le_data_b, data_b);
        end
    endtask

    task automatic test_strobe_exclusive();
        checks++;
        if (overlap_errors !== 0) begin
            failures++;
            $display("[TB] FAIL strobe_exclusive: got %0d violations expected 0", overlap_errors);
        end
    endtask

    // Runs every scenario in order, then prints the summary
    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        test_bit_centre_16();
        test_strobe_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
